// File: rtl/logic_bist_3in.sv
// Built-in self-test sequencer for 3-input combinational blocks.
// Walks ABC = 000..111, waits SETTLE cycles per vector, samples F,
// compares it against the EXPECTED truth table and keeps the results.
module logic_bist_3in #(
    parameter int         SETTLE   = 2,
    parameter logic [7:0] EXPECTED = 8'hCA
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       f_in,
    output logic       a_out,
    output logic       b_out,
    output logic       c_out,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [3:0] fail_cnt,
    output logic [2:0] first_fail,
    output logic       first_fail_valid,
    output logic [7:0] observed
);

    localparam logic [3:0] SETTLE_CNT = 4'(SETTLE);

    typedef enum logic {
        IDLE = 1'b0,
        SCAN = 1'b1
    } state_t;

    state_t     state;
    logic [2:0] idx;
    logic [3:0] cnt;
    logic       mismatch;

    // The applied vector is the index itself, so the outputs come straight from a register.
    assign a_out = idx[2];
    assign b_out = idx[1];
    assign c_out = idx[0];

    // Compare the sampled F against the golden truth table for the current vector.
    always_comb begin
        mismatch = (f_in != EXPECTED[idx]);
    end

    // Scan sequencer: settle countdown, capture, result bookkeeping and done pulse.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state            <= IDLE;
            idx              <= 3'd0;
            cnt              <= 4'd0;
            busy             <= 1'b0;
            done             <= 1'b0;
            pass             <= 1'b0;
            fail_cnt         <= 4'd0;
            first_fail       <= 3'd0;
            first_fail_valid <= 1'b0;
            observed         <= 8'h00;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    idx <= 3'd0;
                    if (start) begin
                        state            <= SCAN;
                        busy             <= 1'b1;
                        cnt              <= SETTLE_CNT;
                        pass             <= 1'b0;
                        fail_cnt         <= 4'd0;
                        first_fail       <= 3'd0;
                        first_fail_valid <= 1'b0;
                        observed         <= 8'h00;
                    end
                end
                SCAN: begin
                    if (cnt != 4'd0) begin
                        cnt <= cnt - 4'd1;
                    end else begin
                        observed[idx] <= f_in;
                        if (mismatch) begin
                            fail_cnt <= fail_cnt + 4'd1;
                            if (!first_fail_valid) begin
                                first_fail       <= idx;
                                first_fail_valid <= 1'b1;
                            end
                        end
                        if (idx != 3'd7) begin
                            idx <= idx + 3'd1;
                            cnt <= SETTLE_CNT;
                        end else begin
                            state <= IDLE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            idx   <= 3'd0;
                            pass  <= (fail_cnt == 4'd0) && !mismatch;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    idx   <= 3'd0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_logic_bist_3in.sv
// Self-checking bench for logic_bist_3in: two instances (SETTLE=2 and SETTLE=0)
// each driving a selectable model of the block under test.
module tb_logic_bist_3in;

    logic clk;
    logic rst_n;
    logic start_a, start_b;
    logic f_a, f_b;
    int   mode_a, mode_b;

    logic       a_a, b_a, c_a, busy_a, done_a, pass_a, ffv_a;
    logic [3:0] fc_a;
    logic [2:0] ff_a;
    logic [7:0] obs_a;

    logic       a_b, b_b, c_b, busy_b, done_b, pass_b, ffv_b;
    logic [3:0] fc_b;
    logic [2:0] ff_b;
    logic [7:0] obs_b;

    int total;
    int bad;

    typedef struct packed {
        logic [2:0] vec;
        logic       busy;
        logic       done;
        logic       pass;
        logic [3:0] fc;
        logic [2:0] ff;
        logic       ffv;
        logic [7:0] obs;
    } snap_t;

    typedef struct {
        logic       pass;
        logic [3:0] fc;
        logic [2:0] ff;
        logic       ffv;
        logic [7:0] obs;
    } exp_t;

    exp_t sb[$];

    // Models of the block under test: 0 = A?B:C, 1 = tied low, 2 = A'C
    function automatic logic fmodel(input int md, input logic [2:0] v);
        case (md)
            0:       return v[2] ? v[1] : v[0];
            1:       return 1'b0;
            default: return ~v[2] & v[0];
        endcase
    endfunction

    assign f_a = fmodel(mode_a, {a_a, b_a, c_a});
    assign f_b = fmodel(mode_b, {a_b, b_b, c_b});

    logic_bist_3in #(.SETTLE(2), .EXPECTED(8'hCA)) dut_a (
        .clk(clk), .rst_n(rst_n), .start(start_a), .f_in(f_a),
        .a_out(a_a), .b_out(b_a), .c_out(c_a), .busy(busy_a), .done(done_a),
        .pass(pass_a), .fail_cnt(fc_a), .first_fail(ff_a),
        .first_fail_valid(ffv_a), .observed(obs_a)
    );

    logic_bist_3in #(.SETTLE(0), .EXPECTED(8'hCA)) dut_b (
        .clk(clk), .rst_n(rst_n), .start(start_b), .f_in(f_b),
        .a_out(a_b), .b_out(b_b), .c_out(c_b), .busy(busy_b), .done(done_b),
        .pass(pass_b), .fail_cnt(fc_b), .first_fail(ff_b),
        .first_fail_valid(ffv_b), .observed(obs_b)
    );

    // Free-running clock, period 10
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic snap_t snap(input int sel);
        snap_t s;
        if (sel == 0) s = '{{a_a, b_a, c_a}, busy_a, done_a, pass_a, fc_a, ff_a, ffv_a, obs_a};
        else          s = '{{a_b, b_b, c_b}, busy_b, done_b, pass_b, fc_b, ff_b, ffv_b, obs_b};
        return s;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic setStart(input int sel, input logic v);
        if (sel == 0) start_a = v;
        else          start_b = v;
    endtask

    // Independent expectation: run all eight vectors through the chosen model
    function automatic exp_t expected_for(input int md);
        exp_t       e;
        logic [7:0] tt;
        logic       f;
        tt    = 8'hCA;
        e.fc  = 4'd0;
        e.ff  = 3'd0;
        e.ffv = 1'b0;
        e.obs = 8'h00;
        for (int k = 0; k < 8; k++) begin
            f = fmodel(md, 3'(k));
            e.obs[k] = f;
            if (f != tt[k]) begin
                e.fc = e.fc + 4'd1;
                if (!e.ffv) begin
                    e.ff  = 3'(k);
                    e.ffv = 1'b1;
                end
            end
        end
        e.pass = (e.fc == 4'd0);
        return e;
    endfunction

    // Pulse start for one edge (E0); returns at the negedge right after E0
    task automatic applyStimulus(input int sel, input int md, input bit push);
        if (sel == 0) mode_a = md;
        else          mode_b = md;
        if (push) sb.push_back(expected_for(md));
        setStart(sel, 1'b1);
        @(negedge clk);
        setStart(sel, 1'b0);
    endtask

    // Follow the scan cycle by cycle until done, checking vector, busy and latency
    task automatic waitDone(input int sel, input int settle, input bit inject);
        int    n;
        int    span;
        snap_t s;
        span = 8 * (settle + 1);
        n    = 0;
        forever begin
            s = snap(sel);
            if (n < span) begin
                checkOutput($sformatf("vec_n%0d", n), 32'(s.vec), 32'(n / (settle + 1)));
                checkOutput($sformatf("busy_n%0d", n), 32'(s.busy), 32'd1);
            end
            if (s.done) break;
            if (n > span + 10) begin
                total++;
                bad++;
                $display("[TB] FAIL done_timeout observed=none expected=done_at_%0d", span);
                break;
            end
            setStart(sel, inject && (n == 4 || n == 11));
            @(negedge clk);
            n++;
        end
        setStart(sel, 1'b0);
        checkOutput("latency", 32'(n), 32'(span));
        checkOutput("busy_at_done", 32'(snap(sel).busy), 32'd0);
    endtask

    task automatic checkResults(input int sel, input string tag);
        exp_t  e;
        snap_t s;
        if (sb.size() == 0) begin
            total++;
            bad++;
            $display("[TB] FAIL %s_scoreboard observed=empty expected=entry", tag);
            return;
        end
        e = sb.pop_front();
        s = snap(sel);
        checkOutput({tag, "_pass"},  32'(s.pass), 32'(e.pass));
        checkOutput({tag, "_fc"},    32'(s.fc),   32'(e.fc));
        checkOutput({tag, "_ff"},    32'(s.ff),   32'(e.ff));
        checkOutput({tag, "_ffv"},   32'(s.ffv),  32'(e.ffv));
        checkOutput({tag, "_obs"},   32'(s.obs),  32'(e.obs));
    endtask

    task automatic checkReset(input int sel, input string tag);
        snap_t s;
        s = snap(sel);
        checkOutput({tag, "_vec"},  32'(s.vec),  32'd0);
        checkOutput({tag, "_busy"}, 32'(s.busy), 32'd0);
        checkOutput({tag, "_done"}, 32'(s.done), 32'd0);
        checkOutput({tag, "_pass"}, 32'(s.pass), 32'd0);
        checkOutput({tag, "_fc"},   32'(s.fc),   32'd0);
        checkOutput({tag, "_ff"},   32'(s.ff),   32'd0);
        checkOutput({tag, "_ffv"},  32'(s.ffv),  32'd0);
        checkOutput({tag, "_obs"},  32'(s.obs),  32'd0);
    endtask

    // Directed sequence of scans against both instances
    initial begin
        int    pulses;
        snap_t s;
        total   = 0;
        bad     = 0;
        rst_n   = 1'b0;
        start_a = 1'b0;
        start_b = 1'b0;
        mode_a  = 0;
        mode_b  = 0;
        repeat (3) @(negedge clk);
        checkReset(0, "rst_a");
        checkReset(1, "rst_b");
        rst_n = 1'b1;
        @(negedge clk);

        $display("[TB] good model, SETTLE=2");
        applyStimulus(0, 0, 1'b1);
        waitDone(0, 2, 1'b0);
        checkResults(0, "good");
        @(negedge clk);
        s = snap(0);
        checkOutput("done_pulse_width", 32'(s.done), 32'd0);
        checkOutput("obs_stable", 32'(s.obs), 32'hCA);

        $display("[TB] f_in tied low");
        applyStimulus(0, 1, 1'b1);
        waitDone(0, 2, 1'b0);
        checkResults(0, "zero");

        $display("[TB] AB term dropped");
        applyStimulus(0, 2, 1'b1);
        waitDone(0, 2, 1'b0);
        checkResults(0, "acterm");

        $display("[TB] start while busy, then start on done cycle");
        applyStimulus(0, 1, 1'b1);
        waitDone(0, 2, 1'b1);
        checkResults(0, "busy_start");
        applyStimulus(0, 0, 1'b1);
        s = snap(0);
        checkOutput("restart_busy", 32'(s.busy), 32'd1);
        checkOutput("restart_done", 32'(s.done), 32'd0);
        checkOutput("restart_fc",   32'(s.fc),   32'd0);
        checkOutput("restart_ffv",  32'(s.ffv),  32'd0);
        checkOutput("restart_ff",   32'(s.ff),   32'd0);
        checkOutput("restart_obs",  32'(s.obs),  32'd0);
        waitDone(0, 2, 1'b0);
        checkResults(0, "restart");

        $display("[TB] reset mid-scan");
        applyStimulus(0, 1, 1'b0);
        repeat (9) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        checkReset(0, "midrst");
        rst_n  = 1'b1;
        pulses = 0;
        repeat (40) begin
            @(negedge clk);
            if (done_a) pulses++;
        end
        checkOutput("midrst_no_done", 32'(pulses), 32'd0);
        checkOutput("midrst_idle", 32'(busy_a), 32'd0);

        $display("[TB] good model, SETTLE=0");
        applyStimulus(1, 0, 1'b1);
        waitDone(1, 0, 1'b0);
        checkResults(1, "settle0");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
